// File: rtl/cam_frame_writer_if.sv
// Bus bundle between the OV7670 capture side and the frame-buffer write port.
// The slave modport is the frame writer. The master modport is the camera and
// buffer environment that drives it.
// Optional feature macro: CAM_FRAME_CHECK_EN adds the frame_err status line.
interface cam_frame_writer_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          frame_done;
`ifdef CAM_FRAME_CHECK_EN
    logic          frame_err;

    modport slave (
        input  vsync, href, px_data,
        output mem_px_addr, mem_px_data, px_wr, frame_done, frame_err
    );

    modport master (
        output vsync, href, px_data,
        input  mem_px_addr, mem_px_data, px_wr, frame_done, frame_err
    );
`else
    modport slave (
        input  vsync, href, px_data,
        output mem_px_addr, mem_px_data, px_wr, frame_done
    );

    modport master (
        output vsync, href, px_data,
        input  mem_px_addr, mem_px_data, px_wr, frame_done
    );
`endif
endinterface

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: write-side client of the dual-port frame buffer.
// This block runs in the camera pixel-clock domain. It captures the OV7670
// RGB565 byte stream, which is framed by vsync and href. It packs each pair of
// bytes into one RGB444 pixel and writes that pixel at the next linear address.
// Addresses restart at 0 after every vsync high->low sequence. Pixels beyond
// IMG_W*IMG_H are dropped, and the address never wraps back into the frame.
// Optional feature macro: CAM_FRAME_CHECK_EN. It adds frame_err, which reports
// whether the last completed frame carried exactly IMG_W*IMG_H pixels.
module cam_frame_writer #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic                clk,
    input  logic                rst,
    cam_frame_writer_if.slave   bus
);

    localparam int NPIX = IMG_W * IMG_H;
    // The counter is one bit wider than the address so that it can hold
    // NPIX == 2**AW as its "frame full" value without wrapping.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] NPIX_C   = CW'(NPIX);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_VSYNC = 3'd1,
        S_IDLE  = 3'd2,
        S_B1    = 3'd3,
        S_B2    = 3'd4
    } state_t;

    // byte1 = {R4..R0,G5..G3}, byte2 = {G2..G0,B4..B0}; keep the top 4 bits of each channel.
    function automatic logic [11:0] rgb565_to_444(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[7:4], b1[2:0], b2[7], b2[4:1]};
    endfunction

    state_t        state_r;
    state_t        state_nx_s;
    logic          latch_s;
    logic          pix_s;
    logic          clr_s;
    logic          end_s;
    logic          wr_s;
    logic          any_wr_s;

    logic [7:0]    byte1_r;
    logic [CW-1:0] addr_cnt_r;
    logic [AW-1:0] mem_px_addr_r;
    logic [DW-1:0] mem_px_data_r;
    logic          px_wr_r;
    logic          frame_done_r;

    // A pixel is written only while the frame still has room.
    assign wr_s     = pix_s && (addr_cnt_r != NPIX_C);
    // frame_done is suppressed for frames that wrote nothing.
    assign any_wr_s = (addr_cnt_r != CNT_ZERO);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_WAIT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and per-cycle control strobes. vsync has priority over href everywhere.
    always_comb begin
        state_nx_s = state_r;
        latch_s    = 1'b0;
        pix_s      = 1'b0;
        clr_s      = 1'b0;
        end_s      = 1'b0;
        case (state_r)
            S_WAIT: begin
                if (bus.vsync) begin
                    state_nx_s = S_VSYNC;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            S_VSYNC: begin
                if (!bus.vsync) begin
                    state_nx_s = S_IDLE;
                    clr_s      = 1'b1;
                end else begin
                    state_nx_s = S_VSYNC;
                end
            end
            S_IDLE: begin
                if (bus.vsync) begin
                    state_nx_s = S_VSYNC;
                    end_s      = 1'b1;
                end else if (bus.href) begin
                    state_nx_s = S_B2;
                    latch_s    = 1'b1;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_B2: begin
                if (bus.vsync) begin
                    state_nx_s = S_VSYNC;
                    end_s      = 1'b1;
                end else if (bus.href) begin
                    state_nx_s = S_B1;
                    pix_s      = 1'b1;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_B1: begin
                if (bus.vsync) begin
                    state_nx_s = S_VSYNC;
                    end_s      = 1'b1;
                end else if (bus.href) begin
                    state_nx_s = S_B2;
                    latch_s    = 1'b1;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            default: begin
                state_nx_s = S_WAIT;
            end
        endcase
    end

    // First-byte latch, address counter and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte1_r       <= 8'h00;
            addr_cnt_r    <= CNT_ZERO;
            mem_px_addr_r <= {AW{1'b0}};
            mem_px_data_r <= {DW{1'b0}};
            px_wr_r       <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            px_wr_r      <= wr_s;
            frame_done_r <= end_s && any_wr_s;
            if (latch_s) begin
                byte1_r <= bus.px_data;
            end
            if (clr_s) begin
                addr_cnt_r <= CNT_ZERO;
            end else if (wr_s) begin
                addr_cnt_r    <= addr_cnt_r + CNT_ONE;
                mem_px_addr_r <= addr_cnt_r[AW-1:0];
                mem_px_data_r <= DW'(rgb565_to_444(byte1_r, bus.px_data));
            end
        end
    end

    assign bus.mem_px_addr = mem_px_addr_r;
    assign bus.mem_px_data = mem_px_data_r;
    assign bus.px_wr       = px_wr_r;
    assign bus.frame_done  = frame_done_r;

`ifdef CAM_FRAME_CHECK_EN
    // The received counter has two spare bits and saturates. An overlong
    // frame therefore can never alias back to NPIX.
    localparam int RW = AW + 2;
    localparam logic [RW-1:0] RX_NPIX = RW'(NPIX);
    localparam logic [RW-1:0] RX_MAX  = {RW{1'b1}};
    localparam logic [RW-1:0] RX_ONE  = {{(RW-1){1'b0}}, 1'b1};

    logic [RW-1:0] rx_cnt_r;
    logic          frame_err_r;

    // Count every completed pixel, dropped ones included, and grade the frame at frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt_r    <= {RW{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            if (clr_s) begin
                rx_cnt_r <= {RW{1'b0}};
            end else if (pix_s && (rx_cnt_r != RX_MAX)) begin
                rx_cnt_r <= rx_cnt_r + RX_ONE;
            end
            if (end_s && any_wr_s) begin
                frame_err_r <= (rx_cnt_r != RX_NPIX);
            end
        end
    end

    assign bus.frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_cam_frame_writer.sv
// Self-checking bench for cam_frame_writer.
// A reduced 16x8 image with AW=7 keeps the run short. With these values
// IMG_W*IMG_H equals 2**AW, so the bounds logic is tested at its widest case.
// The expected writes are queued as each pixel is driven. A monitor pops and
// compares them on every px_wr.
module tb_cam_frame_writer;

    localparam int AW    = 7;
    localparam int DW    = 12;
    localparam int IMG_W = 16;
    localparam int IMG_H = 8;
    localparam int NPIX  = IMG_W * IMG_H;

    logic clk;
    logic rst;

    cam_frame_writer_if #(.AW(AW), .DW(DW)) bus ();

    cam_frame_writer #(
        .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks;
    int errors;
    int wr_cnt;
    int done_cnt;
    int last_addr;
    int m_addr;
    int m_rx;
    logic [AW+DW-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion: rebuild the RGB565 channels, then keep the MSBs.
    function automatic logic [11:0] exp_rgb(input logic [7:0] b1, input logic [7:0] b2);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = b1[7:3];
        g6 = {b1[2:0], b2[7:5]};
        b5 = b2[4:0];
        return {r5[4:1], g6[5:2], b5[4:1]};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (bus.px_wr === 1'b1) begin
            wr_cnt++;
            last_addr = int'(bus.mem_px_addr);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", bus.mem_px_addr, bus.mem_px_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_px_addr, bus.mem_px_data} !== e) begin
                    errors++;
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.mem_px_addr, bus.mem_px_data, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
        end
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        bus.vsync   = v;
        bus.href    = h;
        bus.px_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2);
        drive(1'b0, 1'b1, b1);
        if (m_addr < NPIX) begin
            exp_q.push_back({AW'(m_addr), exp_rgb(b1, b2)});
            m_addr++;
        end
        m_rx++;
        drive(1'b0, 1'b1, b2);
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic start_frame();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        m_addr = 0;
        m_rx   = 0;
    endtask

    task automatic test_reset();
        int w0;
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'hA5);
        drive(1'b0, 1'b1, 8'h5A);
        checks++;
        if ({bus.px_wr, bus.frame_done, bus.mem_px_addr, bus.mem_px_data} !== {(2+AW+DW){1'b0}}) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b done=%b addr=%0d data=%h, required all 0",
                     bus.px_wr, bus.frame_done, bus.mem_px_addr, bus.mem_px_data);
        end
`ifdef CAM_FRAME_CHECK_EN
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_err: got %b, required 0", bus.frame_err);
        end
`endif
        rst = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'(i * 37));
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (wr_cnt !== w0) begin
            errors++;
            $display("FAIL reset_no_write_before_vsync: got %0d writes, required 0", wr_cnt - w0);
        end
    endtask

    task automatic test_pixels();
        int d0;
        start_frame();
        send_pixel(8'hF8, 8'h1F);
        checks++;
        if ({bus.px_wr, bus.mem_px_addr, bus.mem_px_data} !== {1'b1, 7'd0, 12'hF0F}) begin
            errors++;
            $display("FAIL pixel0: got wr=%b addr=%0d data=%h, required wr=1 addr=0 data=f0f",
                     bus.px_wr, bus.mem_px_addr, bus.mem_px_data);
        end
        send_pixel(8'h07, 8'hE0);
        checks++;
        if ({bus.px_wr, bus.mem_px_addr, bus.mem_px_data} !== {1'b1, 7'd1, 12'h0F0}) begin
            errors++;
            $display("FAIL pixel1: got wr=%b addr=%0d data=%h, required wr=1 addr=1 data=0f0",
                     bus.px_wr, bus.mem_px_addr, bus.mem_px_data);
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.px_wr !== 1'b0) begin
            errors++;
            $display("FAIL pixel_wr_pulse: got wr=%b, required 0", bus.px_wr);
        end
        d0 = done_cnt;
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL pixel_frame_done: got %b, required 1", bus.frame_done);
        end
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL pixel_done_width: got %0d cycles, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_full_frame();
        int w0;
        int d0;
        start_frame();
        w0 = wr_cnt;
        for (int l = 0; l < IMG_H; l++) begin
            send_line(IMG_W);
        end
        d0 = done_cnt;
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL full_frame_done: got %b, required 1", bus.frame_done);
        end
`ifdef CAM_FRAME_CHECK_EN
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL full_frame_err: got %b, required 0", bus.frame_err);
        end
`endif
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL full_frame_done_width: got %b, required 0", bus.frame_done);
        end
        checks++;
        if (wr_cnt - w0 !== NPIX || last_addr !== NPIX - 1) begin
            errors++;
            $display("FAIL full_frame_count: got %0d writes last=%0d, required %0d last=%0d",
                     wr_cnt - w0, last_addr, NPIX, NPIX - 1);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL full_frame_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_overflow();
        int w0;
        start_frame();
        w0 = wr_cnt;
        send_line(IMG_W + 1);
        for (int l = 0; l < IMG_H; l++) begin
            send_line(IMG_W);
        end
        checks++;
        if (wr_cnt - w0 !== NPIX || last_addr !== NPIX - 1) begin
            errors++;
            $display("FAIL overflow_stop: got %0d writes last=%0d, required %0d last=%0d",
                     wr_cnt - w0, last_addr, NPIX, NPIX - 1);
        end
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL overflow_done: got %b, required 1", bus.frame_done);
        end
`ifdef CAM_FRAME_CHECK_EN
        checks++;
        if (bus.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_frame_err: got %b, required 1", bus.frame_err);
        end
`endif
    endtask

    task automatic test_odd_bytes();
        int w0;
        start_frame();
        w0 = wr_cnt;
        send_pixel(8'h12, 8'h34);
        drive(1'b0, 1'b1, 8'h56);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (wr_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL odd_bytes_writes: got %0d, required 1", wr_cnt - w0);
        end
        send_line(2);
        checks++;
        if (last_addr !== 2) begin
            errors++;
            $display("FAIL odd_bytes_resume: got last addr %0d, required 2", last_addr);
        end
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_vsync_midline();
        int w0;
        start_frame();
        send_pixel(8'hAA, 8'h55);
        send_pixel(8'h3C, 8'hC3);
        drive(1'b0, 1'b1, 8'h81);
        w0 = wr_cnt;
        drive(1'b1, 1'b1, 8'h7E);
        checks++;
        if ({bus.px_wr, bus.frame_done} !== 2'b01) begin
            errors++;
            $display("FAIL vsync_mid_collide: got wr=%b done=%b, required wr=0 done=1", bus.px_wr, bus.frame_done);
        end
        drive(1'b1, 1'b1, 8'h00);
        checks++;
        if (wr_cnt !== w0) begin
            errors++;
            $display("FAIL vsync_mid_no_write: got %0d writes, required 0", wr_cnt - w0);
        end
        start_frame();
        send_pixel(8'hF8, 8'h00);
        checks++;
        if ({bus.px_wr, bus.mem_px_addr} !== {1'b1, 7'd0}) begin
            errors++;
            $display("FAIL vsync_mid_restart: got wr=%b addr=%0d, required wr=1 addr=0", bus.px_wr, bus.mem_px_addr);
        end
    endtask

    task automatic test_empty_frame();
        int d0;
        start_frame();
        d0 = done_cnt;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL empty_frame_done: got %0d pulses, required 0", done_cnt - d0);
        end
    endtask

    task automatic test_rst_midline();
        int w0;
        start_frame();
        send_pixel(8'h11, 8'h22);
        drive(1'b0, 1'b1, 8'h33);
        w0 = wr_cnt;
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h44);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 8'(i + 1));
        end
        checks++;
        if (wr_cnt !== w0 || bus.px_wr !== 1'b0) begin
            errors++;
            $display("FAIL rst_midline_abort: got %0d writes, required 0", wr_cnt - w0);
        end
        start_frame();
        send_pixel(8'h00, 8'h1E);
        checks++;
        if ({bus.px_wr, bus.mem_px_addr, bus.mem_px_data} !== {1'b1, 7'd0, 12'h00F}) begin
            errors++;
            $display("FAIL rst_midline_resume: got wr=%b addr=%0d data=%h, required wr=1 addr=0 data=00f",
                     bus.px_wr, bus.mem_px_addr, bus.mem_px_data);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        wr_cnt      = 0;
        done_cnt    = 0;
        last_addr   = -1;
        m_addr      = 0;
        m_rx        = 0;
        rst         = 1'b1;
        bus.vsync   = 1'b0;
        bus.href    = 1'b0;
        bus.px_data = 8'h00;
        test_reset();
        test_pixels();
        test_full_frame();
        test_overflow();
        test_odd_bytes();
        test_vsync_midline();
        test_empty_frame();
        test_rst_midline();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
